// File: rtl/x_uart_pkg.sv
// Shared types and helpers for the x_uart blocks.
// Receiver FSM encoding and bit-timing arithmetic.
package x_uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  function automatic int clks_per_bit(
    input int clk_hz,
    input int baud
  );
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/x_uart_sync.sv
// Two-flop synchroniser for an asynchronous pad input.
// Both flops load RST_VAL while reset is held.
module x_uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      meta <= RST_VAL;
      o_q  <= RST_VAL;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/x_uart_rx.sv
// 8N1 UART receiver with one-entry valid/ready holding register.
// Define X_UART_RX_PARITY_EN to add an even-parity bit after the data.
module x_uart_rx
  import x_uart_pkg::*;
#(
  parameter int p_clk_hz = 12000000,
  parameter int p_baud   = 115200
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int P  = clks_per_bit(p_clk_hz, p_baud);
  localparam int H  = P / 2;
  localparam int CW = $clog2(P);

  localparam logic [CW-1:0] P_LAST = CW'(P - 1);
  localparam logic [CW-1:0] H_LAST = CW'(H - 1);
  localparam logic [2:0]    B_LAST = 3'(DATA_BITS - 1);

`ifdef X_UART_RX_PARITY_EN
  localparam rx_state_t AFTER_DATA = PARITY;
`else
  localparam rx_state_t AFTER_DATA = STOP;
`endif

  if (P < 4) begin : g_bad_rate
    $error("x_uart_rx: p_clk_hz/p_baud must be >= 4");
  end

  rx_state_t     state;
  rx_state_t     state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_n;
  logic [7:0]    shreg;
  logic [7:0]    shreg_n;
  logic          rx_s;
  logic          at_half;
  logic          at_full;
  logic          byte_done;
  logic          frame_bad;

  x_uart_sync #(
    .RST_VAL(1'b1)
  ) u_sync (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_d  (i_rx),
    .o_q  (rx_s)
  );

  assign at_half = (cnt == H_LAST);
  assign at_full = (cnt == P_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shreg   <= shreg_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    bit_n   = bit_idx;
    shreg_n = shreg;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (at_half) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (at_full) begin
          cnt_n   = '0;
          shreg_n = {rx_s, shreg[7:1]};
          if (bit_idx == B_LAST) begin
            state_n = AFTER_DATA;
          end else begin
            bit_n = bit_idx + 1'b1;
          end
        end
      end
`ifdef X_UART_RX_PARITY_EN
      PARITY: begin
        if (at_full) begin
          cnt_n   = '0;
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        if (at_full) begin
          cnt_n   = '0;
          state_n = rx_s ? IDLE : BREAK;
        end
      end
      BREAK: begin
        // Hold here through a long low line so only one error is reported.
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

`ifdef X_UART_RX_PARITY_EN
  logic par_err;
  logic par_bad;

  assign par_bad = rx_s ^ (^shreg);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      par_err <= 1'b0;
    end else if (state == START) begin
      par_err <= 1'b0;
    end else if (state == PARITY && at_full) begin
      par_err <= par_bad;
    end
  end
`endif

  always_comb begin
    byte_done = 1'b0;
    frame_bad = 1'b0;
    if (at_full && state == STOP) begin
`ifdef X_UART_RX_PARITY_EN
      byte_done = rx_s & ~par_err;
`else
      byte_done = rx_s;
`endif
      frame_bad = ~rx_s;
    end
`ifdef X_UART_RX_PARITY_EN
    if (at_full && state == PARITY) begin
      frame_bad = par_bad;
    end
`endif
  end

  // A finished byte may replace one being accepted in the same cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_frame_err <= frame_bad;
      o_overrun   <= 1'b0;
      if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
      if (byte_done) begin
        if (!o_valid || i_ready) begin
          o_data  <= shreg;
          o_valid <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_x_uart_rx.sv
// Scoreboard bench for x_uart_rx: serial frames in, bytes and error pulses out.
// Expected delivery time = stop-bit centre + 3 cycles.
module tb_x_uart_rx;

  localparam int CLK_HZ = 12000000;
  localparam int BAUD   = 115200;
  localparam int P      = CLK_HZ / BAUD;
  localparam int H      = P / 2;
`ifdef X_UART_RX_PARITY_EN
  localparam int STOP_IDX = 10;
`else
  localparam int STOP_IDX = 9;
`endif

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic       rx    = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       fe;
  logic       ovr;

  x_uart_rx #(
    .p_clk_hz(CLK_HZ),
    .p_baud  (BAUD)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx       (rx),
    .o_data     (data),
    .o_valid    (valid),
    .i_ready    (ready),
    .o_frame_err(fe),
    .o_overrun  (ovr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    int         at;
  } exp_t;

  exp_t sb[$];
  int checks    = 0;
  int failures  = 0;
  int fe_seen   = 0;
  int ovr_seen  = 0;
  int fe_total  = 0;
  int ovr_total = 0;
`ifdef X_UART_RX_PARITY_EN
  bit flip_par  = 1'b0;
`endif

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on each accepted byte.
  always @(negedge clk) begin
    exp_t e;
    if (fe) fe_seen++;
    if (ovr) ovr_seen++;
    if (valid && ready) begin
      check("byte_expected", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("byte_data", int'(data), int'(e.d));
        if (e.at >= 0) check("byte_time", cyc, e.at);
      end
    end
  end

  task automatic line(input logic v, input int n);
    if (n > 0) begin
      rx = v;
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input bit ok, input int stop_low);
    int   t0 = cyc;
    exp_t e;
    if (ok) begin
      e.d  = b;
      e.at = ready ? t0 + STOP_IDX * P + H + 3 : -1;
      sb.push_back(e);
    end
    line(1'b0, P);
    for (int i = 0; i < 8; i++) line(b[i], P);
`ifdef X_UART_RX_PARITY_EN
    line((^b) ^ flip_par, P);
`endif
    line(1'b0, stop_low);
    line(1'b1, P);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && sb.size() > 0; i++) @(posedge clk);
    #1;
    check({name, "_drain"}, sb.size(), 0);
    check({name, "_frame_err"}, fe_seen, fe_total);
    check({name, "_overrun"}, ovr_seen, ovr_total);
  endtask

  initial begin
    logic [7:0] b;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", int'(valid), 0);
    check("rst_data", int'(data), 0);
    check("rst_frame_err", int'(fe), 0);
    check("rst_overrun", int'(ovr), 0);
    rst = 1'b1;
    line(1'b1, 5);

    send(8'hA5, 1'b1, 0);
    line(1'b1, 20);
    drain("a5");

    line(1'b0, 10);
    line(1'b1, 100);
    drain("glitch");
    send(8'h3C, 1'b1, 0);
    line(1'b1, 20);
    drain("3c");

    send(8'h55, 1'b0, 300);
    fe_total++;
    line(1'b1, 50);
    send(8'h81, 1'b1, 0);
    line(1'b1, 20);
    drain("break");

    ready = 1'b0;
    send(8'h12, 1'b1, 0);
    send(8'h34, 1'b0, 0);
    ovr_total++;
    line(1'b1, 20);
    check("hold_valid", int'(valid), 1);
    check("hold_data", int'(data), 8'h12);
    check("hold_overrun", ovr_seen, ovr_total);
    ready = 1'b1;
    @(posedge clk);
    #1;
    check("accept_drop", int'(valid), 0);
    drain("overrun");

    send(8'h00, 1'b1, 0);
    send(8'hFF, 1'b1, 0);
    line(1'b1, 20);
    drain("b2b");

    b = 8'h77;
    line(1'b0, P);
    for (int i = 0; i < 3; i++) line(b[i], P);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_valid", int'(valid), 0);
    check("mid_rst_data", int'(data), 0);
    check("mid_rst_frame_err", int'(fe), 0);
    check("mid_rst_overrun", int'(ovr), 0);
    line(1'b1, 5);
    rst = 1'b1;
    line(1'b1, 50);
    send(8'h42, 1'b1, 0);
    line(1'b1, 20);
    drain("rst42");

`ifdef X_UART_RX_PARITY_EN
    send(8'h03, 1'b1, 0);
    line(1'b1, 20);
    drain("par_ok");
    flip_par = 1'b1;
    send(8'h03, 1'b0, 0);
    flip_par = 1'b0;
    fe_total++;
    line(1'b1, 20);
    drain("par_bad");
`endif

    for (int k = 0; k < 12; k++) begin
      send(8'($urandom), 1'b1, 0);
      line(1'b1, $urandom_range(0, 40));
    end
    line(1'b1, 20);
    drain("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
